// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and the controller that drives it.
//   - FSM state encoding of the responder
//   - address-source select codes for msel
//   - register-file write-back select code for the mdata path
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } mem_state_t;

    localparam logic MSEL_PC   = 1'b0;
    localparam logic MSEL_DATA = 1'b1;

    // vsel code that routes mdata into the register file
    localparam logic [1:0] VSEL_MDATA = 2'b00;

    // width of the wait-state counter (WAIT_CYCLES range 0..15)
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_responder_ram_array.sv
// ram_array: single-port synchronous RAM, unified instruction/data store.
//   clk   - rising-edge clock
//   we    - write enable, wdata is written to addr at the clock edge
//   re    - read-address enable, addr is registered at the clock edge
//   addr  - word address
//   wdata - write data
//   rdata - word at the registered read address
// Contents are not reset.
module ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [ADDR_W-1:0] addr_r;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            addr_r <= addr;
        end
    end

    assign rdata = mem[addr_r];

endmodule

// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the RISC controller.
// Accepts fetch (msel=0, address pc) and load/store (msel=1, address addr_c)
// requests in IDLE, inserts WAIT_CYCLES stall cycles and pulses mready once.
//   clk, reset     - clock, asynchronous active-high reset
//   mreq           - request strobe (sampled in IDLE only)
//   msel           - address source: 0 = pc, 1 = addr_c (low ADDR_W bits)
//   mwrite         - 1 = store, 0 = load/fetch
//   pc, addr_c     - address sources
//   din            - store data
//   mdata          - read data, valid with mready, held until the next load
//   mready         - one-cycle completion pulse
//   busy           - high from acceptance through the RESP cycle
//   merr           - write-protect violation, valid with mready
// Optional feature: MEM_WRITE_PROTECT_EN suppresses stores below PROT_TOP.
//
// state  | meaning
// IDLE   | waiting for mreq; request fields latched on accept
// ACCESS | RAM write commits / read address registered
// WAIT   | WAIT_CYCLES stall cycles
// RESP   | mready pulse, load data presented on mdata
module mem_responder import mem_pkg::*; #(
    parameter int                 ADDR_W      = 8,
    parameter int                 DATA_W      = 16,
    parameter int                 WAIT_CYCLES = 1,
    parameter logic [ADDR_W-1:0]  PROT_TOP    = 8'h10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mreq,
    input  logic              msel,
    input  logic              mwrite,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] addr_c,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] mdata,
    output logic              mready,
    output logic              busy,
    output logic              merr
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_q;
    logic [DATA_W-1:0] din_q;
    logic [DATA_W-1:0] mdata_q;
    logic [DATA_W-1:0] ram_rdata;
    logic [WAIT_W-1:0] wait_cnt;
    logic              ram_we, ram_re;
    logic              prot_hit;
    logic              load_resp;

    // upper addr_c bits are intentionally dropped (address aliasing)
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr_c[DATA_W-1:ADDR_W];

`ifdef MEM_WRITE_PROTECT_EN
    assign prot_hit = wr_q && (addr_q < PROT_TOP);
`else
    assign prot_hit = 1'b0;
    logic unused_prot;
    assign unused_prot = ^PROT_TOP;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mready    = 1'b0;
        busy      = 1'b1;
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (mreq) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                ram_we    = wr_q && !prot_hit;
                ram_re    = !wr_q;
                state_nxt = (WAIT_CYCLES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                mready    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            din_q  <= '0;
        end else if (state == IDLE && mreq) begin
            addr_q <= (msel == MSEL_DATA) ? addr_c[ADDR_W-1:0] : pc;
            wr_q   <= mwrite;
            din_q  <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == ACCESS) begin
            wait_cnt <= WAIT_LOAD;
        end else if (state == WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    // RAM read data is already valid in RESP (address registered in ACCESS),
    // so it is passed straight through and captured for holding afterwards.
    assign load_resp = (state == RESP) && !wr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdata_q <= '0;
        end else if (load_resp) begin
            mdata_q <= ram_rdata;
        end
    end

    assign mdata = load_resp ? ram_rdata : mdata_q;
    assign merr  = mready && prot_hit;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (addr_q),
        .wdata (din_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (WAIT_CYCLES=1 and 0) share the
// request inputs; expected responses are queued per instance at issue time
// and a monitor per instance checks each mready pulse against its queue.
module tb_mem_responder;

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [15:0] md;
        logic        err;
        bit          chk_md;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        mreq, msel, mwrite;
    logic [7:0]  pc;
    logic [15:0] addr_c, din;
    logic [15:0] mdata0, mdata1;
    logic        mready0, mready1, busy0, busy1, merr0, merr1;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(1), .PROT_TOP(8'h10)) u_dut1 (
        .clk(clk), .reset(rst1), .mreq(mreq), .msel(msel), .mwrite(mwrite),
        .pc(pc), .addr_c(addr_c), .din(din),
        .mdata(mdata1), .mready(mready1), .busy(busy1), .merr(merr1)
    );

    mem_responder #(.ADDR_W(8), .DATA_W(16), .WAIT_CYCLES(0), .PROT_TOP(8'h10)) u_dut0 (
        .clk(clk), .reset(rst0), .mreq(mreq), .msel(msel), .mwrite(mwrite),
        .pc(pc), .addr_c(addr_c), .din(din),
        .mdata(mdata0), .mready(mready0), .busy(busy0), .merr(merr0)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: a missing pulse is flagged one cycle after its expected cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q1.size() > 0 && cyc > q1[0].cyc) begin
            checks++; errors++;
            $display("FAIL w1_missing_mready: no pulse, expected at cycle %0d", q1[0].cyc);
            void'(q1.pop_front());
        end
        if (mready1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL w1_spurious_mready: pulse at cycle %0d, expected none", cyc);
            end else begin
                e = q1.pop_front();
                if (cyc != e.cyc || merr1 !== e.err || (e.chk_md && mdata1 !== e.md)) begin
                    errors++;
                    $display("FAIL w1_resp: cycle %0d mdata %h merr %b, expected cycle %0d mdata %h merr %b",
                             cyc, mdata1, merr1, e.cyc, e.md, e.err);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0 && cyc > q0[0].cyc) begin
            checks++; errors++;
            $display("FAIL w0_missing_mready: no pulse, expected at cycle %0d", q0[0].cyc);
            void'(q0.pop_front());
        end
        if (mready0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL w0_spurious_mready: pulse at cycle %0d, expected none", cyc);
            end else begin
                e = q0.pop_front();
                if (cyc != e.cyc || merr0 !== e.err || (e.chk_md && mdata0 !== e.md)) begin
                    errors++;
                    $display("FAIL w0_resp: cycle %0d mdata %h merr %b, expected cycle %0d mdata %h merr %b",
                             cyc, mdata0, merr0, e.cyc, e.md, e.err);
                end
            end
        end
    end

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            mreq = 1'b0;
            #1;
            if (q0.size() == 0 && q1.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: %0d/%0d responses outstanding, expected 0", q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    // Issue one request; dup keeps mreq high through cycles 1-2 with a store
    // to 0x20 that both responders must ignore.
    task automatic issue(input logic s, input logic w, input logic [7:0] p,
                         input logic [15:0] ac, input logic [15:0] d,
                         input logic [15:0] md0, input logic [15:0] md1,
                         input logic err, input bit chk_md, input bit dup);
        int c0;
        @(negedge clk);
        msel = s; mwrite = w; pc = p; addr_c = ac; din = d; mreq = 1'b1;
        c0 = cyc;
        q0.push_back('{c0 + 2, md0, err, chk_md});
        q1.push_back('{c0 + 3, md1, err, chk_md});
        @(negedge clk);
        if (dup) begin
            msel = 1'b1; mwrite = 1'b1; addr_c = 16'h0020; din = 16'h1111;
        end else begin
            mreq = 1'b0;
        end
        #1;
        chk("busy1_cycle1", {15'd0, busy1}, 16'd1);
        chk("busy0_cycle1", {15'd0, busy0}, 16'd1);
        @(negedge clk);
        if (!dup) mreq = 1'b0;
        wait_drain();
        @(negedge clk);
        #1;
        chk("busy1_after", {15'd0, busy1}, 16'd0);
        chk("busy0_after", {15'd0, busy0}, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        mreq = 1'b0; msel = 1'b0; mwrite = 1'b0; pc = '0; addr_c = '0; din = '0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        #1;
        chk("rst_mdata1",  mdata1, 16'h0);
        chk("rst_mdata0",  mdata0, 16'h0);
        chk("rst_mready1", {15'd0, mready1}, 16'd0);
        chk("rst_busy1",   {15'd0, busy1}, 16'd0);
        chk("rst_merr1",   {15'd0, merr1}, 16'd0);
        chk("rst_busy0",   {15'd0, busy0}, 16'd0);

        //     msel  wr    pc     addr_c     din       md0       md1       merr  chk  dup
        issue(1'b1, 1'b1, 8'h00, 16'h0012, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 8'h00, 16'h0012, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        chk("hold_mdata1", mdata1, 16'hABCD);
        chk("hold_mdata0", mdata0, 16'hABCD);
        issue(1'b0, 1'b0, 8'h12, 16'h0000, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 8'h00, 16'h0112, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 8'h00, 16'h0020, 16'h2222, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 8'h00, 16'h0020, 16'h0000, 16'h2222, 16'h2222, 1'b0, 1'b1, 1'b0);
        // busy ignore: load 0x12 with a second request held during cycles 1-2
        issue(1'b1, 1'b0, 8'h00, 16'h0012, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b1);
        issue(1'b1, 1'b0, 8'h00, 16'h0020, 16'h0000, 16'h2222, 16'h2222, 1'b0, 1'b1, 1'b0);

        // reset of the WAIT_CYCLES=1 instance while its load of 0x12 is in WAIT
        @(negedge clk);
        msel = 1'b1; mwrite = 1'b0; addr_c = 16'h0012; mreq = 1'b1;
        q0.push_back('{cyc + 2, 16'hABCD, 1'b0, 1'b1});
        @(negedge clk);
        mreq = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        q1.delete();
        chk("midrst_busy1",   {15'd0, busy1}, 16'd0);
        chk("midrst_mdata1",  mdata1, 16'h0);
        chk("midrst_mready1", {15'd0, mready1}, 16'd0);
        @(negedge clk);
        rst1 = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        chk("midrst_q0_drained", 16'(q0.size()), 16'd0);
        chk("midrst_mdata1_hold", mdata1, 16'h0);

        issue(1'b1, 1'b0, 8'h00, 16'h0012, 16'h0000, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);

        // 0x10 is the first writable address when protection is enabled
        issue(1'b1, 1'b1, 8'h00, 16'h0010, 16'h7777, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1'b0, 8'h00, 16'h0010, 16'h0000, 16'h7777, 16'h7777, 1'b0, 1'b1, 1'b0);
        issue(1'b1, 1'b1, 8'h00, 16'h0005, 16'h5555, 16'h7777, 16'h7777, PROT, 1'b1, 1'b0);
        // with protection 0x05 was never written, so its data is not checked
        issue(1'b1, 1'b0, 8'h00, 16'h0005, 16'h0000, 16'h5555, 16'h5555, 1'b0, !PROT, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
